// File: rtl/axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter
//
// Two-requester AXI write-channel arbiter. Requesters m0 and m1 share one
// downstream write slave (s_). A single owner is granted from the AW request
// until its B handshake completes; all three channels are steered
// combinationally to/from the owner while the FSM sits in the matching phase.
// Arbitration is round-robin: the pointer starts at m0 and, after every
// grant, points at the requester that was not granted.
//
// Optional feature (macro AXI_WR_ARB_LEN_CHECK_EN):
//   Counts W beats per burst and compares the beat carrying wlast against the
//   AW length. A mismatch sets the sticky len_err flag and turns the B
//   response of that burst into SLVERR. Without the macro, len_err is tied
//   low and B responses pass through unmodified.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mN_aw*  / mN_awready        requester N write-address channel
//   mN_w*   / mN_wready         requester N write-data channel
//   mN_b*   / mN_bready         requester N write-response channel
//   s_aw*, s_w*, s_b*           shared downstream slave channels
//   len_err                     sticky burst-length error flag
// ---------------------------------------------------------------------------
module axi_wr_arbiter #(
    parameter int unsigned AWID_WIDTH   = 4,
    parameter int unsigned AWADDR_WIDTH = 11,
    parameter int unsigned WDATA_WIDTH  = 32,
    parameter int unsigned WSTRB_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [AWID_WIDTH-1:0]   m0_awid,
    input  logic [AWADDR_WIDTH-1:0] m0_awaddr,
    input  logic [7:0]              m0_awlen,
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [WDATA_WIDTH-1:0]  m0_wdata,
    input  logic [WSTRB_WIDTH-1:0]  m0_wstrb,
    input  logic                    m0_wlast,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    output logic [AWID_WIDTH-1:0]   m0_bid,
    output logic [1:0]              m0_bresp,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,

    input  logic [AWID_WIDTH-1:0]   m1_awid,
    input  logic [AWADDR_WIDTH-1:0] m1_awaddr,
    input  logic [7:0]              m1_awlen,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [WDATA_WIDTH-1:0]  m1_wdata,
    input  logic [WSTRB_WIDTH-1:0]  m1_wstrb,
    input  logic                    m1_wlast,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    output logic [AWID_WIDTH-1:0]   m1_bid,
    output logic [1:0]              m1_bresp,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,

    output logic [AWID_WIDTH-1:0]   s_awid,
    output logic [AWADDR_WIDTH-1:0] s_awaddr,
    output logic [7:0]              s_awlen,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [WDATA_WIDTH-1:0]  s_wdata,
    output logic [WSTRB_WIDTH-1:0]  s_wstrb,
    output logic                    s_wlast,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    input  logic [AWID_WIDTH-1:0]   s_bid,
    input  logic [1:0]              s_bresp,
    input  logic                    s_bvalid,
    output logic                    s_bready,

    output logic                    len_err
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;    // 0: m0 owns the slave, 1: m1 owns it
    logic   prio_q, prio_d;  // requester favoured when both ask at once
    logic   aw_hs, w_hs;
    logic [1:0] bresp_fwd;

    // Channel outputs are zero outside their phase, so these only fire there.
    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid & s_wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    logic [7:0] beat_q;
    logic [7:0] awlen_q;
    logic       burst_err_q;
    logic       len_err_q;
    logic       beat_err;

    // wlast must appear on exactly the beat whose index equals awlen.
    assign beat_err = s_wlast ^ (beat_q == awlen_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= 8'd0;
            awlen_q     <= 8'd0;
            burst_err_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else if (aw_hs) begin
            beat_q      <= 8'd0;
            awlen_q     <= s_awlen;
            burst_err_q <= 1'b0;
        end else if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (beat_err) begin
                burst_err_q <= 1'b1;
                len_err_q   <= 1'b1;
            end
        end
    end

    assign bresp_fwd = burst_err_q ? 2'b10 : s_bresp;
    assign len_err   = len_err_q;
`else
    assign bresp_fwd = s_bresp;
    assign len_err   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        prio_d     = prio_q;

        s_awid     = '0;
        s_awaddr   = '0;
        s_awlen    = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;

        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bid     = '0;
        m0_bresp   = 2'b00;
        m0_bvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bid     = '0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_awvalid || m1_awvalid) begin
                    if (m0_awvalid && m1_awvalid) gnt_d = prio_q;
                    else                          gnt_d = m1_awvalid;
                    prio_d  = ~gnt_d;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                s_awid    = gnt_q ? m1_awid    : m0_awid;
                s_awaddr  = gnt_q ? m1_awaddr  : m0_awaddr;
                s_awlen   = gnt_q ? m1_awlen   : m0_awlen;
                s_awvalid = gnt_q ? m1_awvalid : m0_awvalid;
                if (gnt_q) m1_awready = s_awready;
                else       m0_awready = s_awready;
                if (s_awvalid && s_awready) state_d = StData;
            end
            StData: begin
                s_wdata  = gnt_q ? m1_wdata  : m0_wdata;
                s_wstrb  = gnt_q ? m1_wstrb  : m0_wstrb;
                s_wlast  = gnt_q ? m1_wlast  : m0_wlast;
                s_wvalid = gnt_q ? m1_wvalid : m0_wvalid;
                if (gnt_q) m1_wready = s_wready;
                else       m0_wready = s_wready;
                if (s_wvalid && s_wready && s_wlast) state_d = StResp;
            end
            StResp: begin
                s_bready = gnt_q ? m1_bready : m0_bready;
                if (gnt_q) begin
                    m1_bvalid = s_bvalid;
                    m1_bid    = s_bid;
                    m1_bresp  = bresp_fwd;
                end else begin
                    m0_bvalid = s_bvalid;
                    m0_bid    = s_bid;
                    m0_bresp  = bresp_fwd;
                end
                if (s_bvalid && s_bready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arbiter
//
// Scoreboard bench for axi_wr_arbiter. Each scenario pushes the AW and W
// transfers it expects to see on the slave side (in expected grant order);
// a slave model pops and compares them as handshakes occur. Requester tasks
// check their own B responses. Honours AXI_WR_ARB_LEN_CHECK_EN if defined.
// ---------------------------------------------------------------------------
module tb_axi_wr_arbiter;

    localparam int unsigned IW  = 4;
    localparam int unsigned AW  = 11;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int          TMO = 200;

`ifdef AXI_WR_ARB_LEN_CHECK_EN
    localparam bit LenChk = 1'b1;
`else
    localparam bit LenChk = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [1:0]         m_bvalid, m_bready;
    logic [1:0][IW-1:0] m_awid, m_bid;
    logic [1:0][AW-1:0] m_awaddr;
    logic [1:0][7:0]    m_awlen;
    logic [1:0][DW-1:0] m_wdata;
    logic [1:0][SW-1:0] m_wstrb;
    logic [1:0][1:0]    m_bresp;

    logic [IW-1:0] s_awid, s_bid;
    logic [AW-1:0] s_awaddr;
    logic [7:0]    s_awlen;
    logic          s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic [1:0]    s_bresp;
    logic          s_bvalid, s_bready;
    logic          len_err;

    axi_wr_arbiter #(
        .AWID_WIDTH  (IW),
        .AWADDR_WIDTH(AW),
        .WDATA_WIDTH (DW),
        .WSTRB_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_awid   (m_awid[0]),
        .m0_awaddr (m_awaddr[0]),
        .m0_awlen  (m_awlen[0]),
        .m0_awvalid(m_awvalid[0]),
        .m0_awready(m_awready[0]),
        .m0_wdata  (m_wdata[0]),
        .m0_wstrb  (m_wstrb[0]),
        .m0_wlast  (m_wlast[0]),
        .m0_wvalid (m_wvalid[0]),
        .m0_wready (m_wready[0]),
        .m0_bid    (m_bid[0]),
        .m0_bresp  (m_bresp[0]),
        .m0_bvalid (m_bvalid[0]),
        .m0_bready (m_bready[0]),
        .m1_awid   (m_awid[1]),
        .m1_awaddr (m_awaddr[1]),
        .m1_awlen  (m_awlen[1]),
        .m1_awvalid(m_awvalid[1]),
        .m1_awready(m_awready[1]),
        .m1_wdata  (m_wdata[1]),
        .m1_wstrb  (m_wstrb[1]),
        .m1_wlast  (m_wlast[1]),
        .m1_wvalid (m_wvalid[1]),
        .m1_wready (m_wready[1]),
        .m1_bid    (m_bid[1]),
        .m1_bresp  (m_bresp[1]),
        .m1_bvalid (m_bvalid[1]),
        .m1_bready (m_bready[1]),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .len_err   (len_err)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] bresp_cfg = 2'b00;
    int         aw_stall  = 0;
    int         w_stall   = 0;
    bit         quiet_m1  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] beat_data(input int m, input logic [AW-1:0] addr,
                                                input int i);
        return {addr, 5'(m), 8'(i), 8'hA5};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int i);
        return 4'(15 - i);
    endfunction

    task automatic expect_burst(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [7:0] len, input int nbeats, input int lastidx);
        aw_q.push_back('{id: id, addr: addr, len: len});
        for (int i = 0; i < nbeats; i++)
            w_q.push_back('{data: beat_data(m, addr, i), strb: beat_strb(i), last: (i == lastidx)});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len);
        bit hs;
        int n;
        m_awid[m]    = id;
        m_awaddr[m]  = addr;
        m_awlen[m]   = len;
        m_awvalid[m] = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < TMO) begin
            @(negedge clk);
            hs = m_awready[m];
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check_eq("aw_timeout", 0, 1);
        m_awvalid[m] = 1'b0;
        m_awid[m]    = '0;
        m_awaddr[m]  = '0;
        m_awlen[m]   = '0;
    endtask

    task automatic do_w(input int m, input logic [AW-1:0] addr, input int nbeats,
                        input int lastidx);
        bit hs;
        int n;
        for (int i = 0; i < nbeats; i++) begin
            m_wdata[m]  = beat_data(m, addr, i);
            m_wstrb[m]  = beat_strb(i);
            m_wlast[m]  = (i == lastidx);
            m_wvalid[m] = 1'b1;
            hs = 1'b0;
            n  = 0;
            while (!hs && n < TMO) begin
                @(negedge clk);
                hs = m_wready[m];
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs) check_eq("w_timeout", 0, 1);
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        m_wdata[m]  = '0;
        m_wstrb[m]  = '0;
    endtask

    task automatic do_b(input int m, input logic [IW-1:0] id, input logic [1:0] exp_resp,
                        input int bstall);
        bit hs;
        int n;
        idle(bstall);
        m_bready[m] = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < TMO) begin
            @(negedge clk);
            hs = m_bvalid[m];
            if (hs) check_eq("b_resp", {m_bid[m], m_bresp[m]}, {id, exp_resp});
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) check_eq("b_timeout", 0, 1);
        m_bready[m] = 1'b0;
    endtask

    task automatic run_burst(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input int nbeats, input int lastidx,
                             input logic [1:0] exp_resp, input int bstall);
        do_aw(m, id, addr, len);
        do_w(m, addr, nbeats, lastidx);
        do_b(m, id, exp_resp, bstall);
    endtask

    // Single burst from an idle arbiter, also checking AW forwarding latency.
    task automatic lat_burst(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input int nbeats);
        fork
            do_aw(m, id, addr, len);
            begin
                @(negedge clk);
                check_eq("aw_lat_n", s_awvalid, 0);
                @(negedge clk);
                check_eq("aw_lat_n1", s_awvalid, 1);
            end
        join
        do_w(m, addr, nbeats, nbeats - 1);
        do_b(m, id, bresp_cfg, 0);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_aw_left"}, aw_q.size(), 0);
        check_eq({tag, "_w_left"}, w_q.size(), 0);
    endtask

    // Slave model and scoreboard consumer.
    initial begin
        bit            aw_hs, w_hs, b_hs, w_last;
        logic [IW-1:0] cur_id;
        aw_exp_t       ea;
        w_exp_t        ew;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bvalid  = 1'b0;
        s_bid     = '0;
        s_bresp   = 2'b00;
        cur_id    = '0;
        forever begin
            @(negedge clk);
            aw_hs  = s_awvalid && s_awready;
            w_hs   = s_wvalid && s_wready;
            b_hs   = s_bvalid && s_bready;
            w_last = s_wlast;
            check_eq("one_owner", {&m_awready, &m_wready, &m_bvalid}, 0);
            if (quiet_m1) check_eq("m1_quiet", {m_awready[1], m_wready[1], m_bvalid[1]}, 0);
            if (aw_hs) begin
                if (aw_q.size() == 0) check_eq("aw_unexpected", 1, 0);
                else begin
                    ea = aw_q.pop_front();
                    check_eq("aw_xfer", {s_awid, s_awaddr, s_awlen}, ea);
                end
                cur_id = s_awid;
            end else if (s_awvalid && aw_q.size() > 0) begin
                check_eq("aw_hold", {s_awid, s_awaddr, s_awlen}, aw_q[0]);
            end
            if (w_hs) begin
                if (w_q.size() == 0) check_eq("w_unexpected", 1, 0);
                else begin
                    ew = w_q.pop_front();
                    check_eq("w_xfer", {s_wdata, s_wstrb, s_wlast}, ew);
                end
            end else if (s_wvalid && w_q.size() > 0) begin
                check_eq("w_hold", {s_wdata, s_wstrb, s_wlast}, w_q[0]);
            end
            if (aw_stall > 0 && s_awvalid) aw_stall--;
            if (w_stall > 0 && s_wvalid) w_stall--;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_bvalid = 1'b0;
                s_bid    = '0;
                s_bresp  = 2'b00;
            end else begin
                if (b_hs) begin
                    s_bvalid = 1'b0;
                    s_bid    = '0;
                    s_bresp  = 2'b00;
                end
                if (w_hs && w_last) begin
                    s_bvalid = 1'b1;
                    s_bid    = cur_id;
                    s_bresp  = bresp_cfg;
                end
            end
            s_awready = (aw_stall == 0);
            s_wready  = (w_stall == 0);
        end
    end

    initial begin
        m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0;
        m_wvalid  = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0;
        m_bready  = '0;

        // Reset: outputs quiet even with a request pending.
        m_awvalid[0] = 1'b1;
        #12;
        check_eq("rst_s_valids", {s_awvalid, s_wvalid, s_bready}, 0);
        check_eq("rst_m_readys", {m_awready, m_wready, m_bvalid}, 0);
        check_eq("rst_len_err", len_err, 0);
        m_awvalid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Simultaneous requests from reset: m0, m1, m0, m1.
        expect_burst(0, 4'h1, 11'h010, 8'd1, 2, 1);
        expect_burst(1, 4'h2, 11'h020, 8'd1, 2, 1);
        expect_burst(0, 4'h3, 11'h030, 8'd0, 1, 0);
        expect_burst(1, 4'h4, 11'h040, 8'd2, 3, 2);
        fork
            begin
                run_burst(0, 4'h1, 11'h010, 8'd1, 2, 1, 2'b00, 0);
                run_burst(0, 4'h3, 11'h030, 8'd0, 1, 0, 2'b00, 0);
            end
            begin
                run_burst(1, 4'h2, 11'h020, 8'd1, 2, 1, 2'b00, 0);
                run_burst(1, 4'h4, 11'h040, 8'd2, 3, 2, 2'b00, 0);
            end
        join
        check_drained("rr");
        idle(2);

        // m0 alone, 4 beats, m1 must stay quiet.
        quiet_m1 = 1'b1;
        expect_burst(0, 4'h5, 11'h123, 8'd3, 4, 3);
        lat_burst(0, 4'h5, 11'h123, 8'd3, 4);
        quiet_m1 = 1'b0;
        check_drained("single");
        idle(2);

        // Backpressure on every channel.
        aw_stall = 5;
        w_stall  = 5;
        idle(2);
        bresp_cfg = 2'b01;
        expect_burst(0, 4'h6, 11'h1F0, 8'd3, 4, 3);
        run_burst(0, 4'h6, 11'h1F0, 8'd3, 4, 3, 2'b01, 5);
        bresp_cfg = 2'b00;
        check_drained("stall");
        idle(2);

        // m1 hogging, m0 asks once: m1, m0, m1, m1.
        expect_burst(1, 4'h7, 11'h300, 8'd3, 4, 3);
        expect_burst(0, 4'h8, 11'h310, 8'd1, 2, 1);
        expect_burst(1, 4'h9, 11'h320, 8'd1, 2, 1);
        expect_burst(1, 4'hA, 11'h330, 8'd1, 2, 1);
        fork
            begin
                run_burst(1, 4'h7, 11'h300, 8'd3, 4, 3, 2'b00, 0);
                run_burst(1, 4'h9, 11'h320, 8'd1, 2, 1, 2'b00, 0);
                run_burst(1, 4'hA, 11'h330, 8'd1, 2, 1, 2'b00, 0);
            end
            begin
                idle(3);
                run_burst(0, 4'h8, 11'h310, 8'd1, 2, 1, 2'b00, 0);
            end
        join
        check_drained("fair");
        idle(2);

        // Short burst: wlast on beat 1 of an awlen=3 burst.
        expect_burst(0, 4'hB, 11'h400, 8'd3, 2, 1);
        run_burst(0, 4'hB, 11'h400, 8'd3, 2, 1, LenChk ? 2'b10 : 2'b00, 0);
        check_eq("len_err_set", len_err, LenChk);
        idle(1);
        bresp_cfg = 2'b01;
        expect_burst(0, 4'hC, 11'h410, 8'd1, 2, 1);
        run_burst(0, 4'hC, 11'h410, 8'd1, 2, 1, 2'b01, 0);
        bresp_cfg = 2'b00;
        check_eq("len_err_sticky", len_err, LenChk);
        check_drained("len");
        idle(2);

        // Reset while beat 2 of a burst is on the W channel.
        expect_burst(0, 4'hD, 11'h500, 8'd3, 4, 3);
        do_aw(0, 4'hD, 11'h500, 8'd3);
        do_w(0, 11'h500, 2, -1);
        m_wdata[0]  = beat_data(0, 11'h500, 2);
        m_wstrb[0]  = beat_strb(2);
        m_wlast[0]  = 1'b0;
        m_wvalid[0] = 1'b1;
        #1;
        check_eq("pre_rst_wvalid", s_wvalid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_s", {s_awvalid, s_wvalid, s_bready}, 0);
        check_eq("mid_rst_m", {m_awready, m_wready, m_bvalid}, 0);
        check_eq("mid_rst_len_err", len_err, 0);
        m_wvalid[0] = 1'b0;
        m_wdata[0]  = '0;
        m_wstrb[0]  = '0;
        check_eq("mid_rst_w_left", w_q.size(), 2);
        w_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_bvalid", {s_bvalid, m_bvalid}, 0);
        expect_burst(0, 4'hE, 11'h600, 8'd2, 3, 2);
        lat_burst(0, 4'hE, 11'h600, 8'd2, 3);
        check_drained("post_rst");
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
